imem_responder: RTL

Responder end of the instruction-fetch port: accepts word read requests driven by the fetch stage (`imem_addr`/`imem_rmask`) and answers each with a single-cycle `imem_resp` pulse carrying `imem_rdata`. Holds one 256-bit line buffer. Hits are answered the next cycle. Misses are filled by a 4-beat burst from the backing memory. Sits between the pipelined core's fetch stage and the burst memory interface.

---
 rtl/rv32i_types.sv | 23 ++
 rtl/line_buffer.sv | 69 ++++++
 rtl/imem_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
//   Shared types and constants for the instruction-fetch responder.
//   - imem_state_t : responder FSM states
//   - LINE_BITS    : line buffer width in bits
//   - OFFSET_BITS  : byte-offset bits within a line
//   - TAG_BITS     : address bits above the line offset
// ---------------------------------------------------------------------------
package rv32i_types;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned TAG_BITS    = 32 - OFFSET_BITS;

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        MREQ,
        MFILL,
        RESP
    } imem_state_t;

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
//   Single 256-bit instruction line with its tag and valid bit.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset (clears valid/tag)
//     beat_we_i       : write one beat of line data
//     beat_idx_i      : beat position within the line
//     beat_data_i     : beat data
//     tag_we_i        : load tag_i (end of a fill)
//     set_valid_i     : mark the line valid together with the tag load
//     tag_i           : tag to store
//     inval_i         : clear valid (wins over set_valid_i)
//     word_idx_i      : 32-bit word select for the read mux
//     word_o          : selected word
//     tag_o, valid_o  : stored tag and valid bit
// ---------------------------------------------------------------------------
module line_buffer
    import rv32i_types::*;
#(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BMEM_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     beat_we_i,
    input  logic [$clog2(BEATS)-1:0] beat_idx_i,
    input  logic [BMEM_W-1:0]        beat_data_i,
    input  logic                     tag_we_i,
    input  logic                     set_valid_i,
    input  logic [TAG_BITS-1:0]      tag_i,
    input  logic                     inval_i,
    input  logic [2:0]               word_idx_i,
    output logic [31:0]              word_o,
    output logic [TAG_BITS-1:0]      tag_o,
    output logic                     valid_o
);

    logic [LINE_BITS-1:0] data_q;
    logic [TAG_BITS-1:0]  tag_q;
    logic                 valid_q;

    // Line data carries no reset; valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (beat_we_i) begin
            data_q[int'(beat_idx_i) * BMEM_W +: BMEM_W] <= beat_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (tag_we_i) begin
                tag_q <= tag_i;
            end
            if (inval_i) begin
                valid_q <= 1'b0;
            end else if (tag_we_i && set_valid_i) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign word_o  = data_q[int'(word_idx_i) * 32 +: 32];
    assign tag_o   = tag_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Responder end of the instruction-fetch port. A one-line buffer answers
//   hits one cycle after the request; misses fetch the line with a BEATS-beat
//   burst and answer one cycle after the last beat. Exactly one imem_resp
//   pulse per accepted request.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     imem_addr    : fetch address (bits [1:0] ignored)
//     imem_rmask   : request when nonzero (sampled only in IDLE)
//     imem_rdata   : instruction word, zero when imem_resp=0
//     imem_resp    : one-cycle response pulse
//     inval        : invalidate the line buffer
//     bmem_addr    : line-aligned burst address
//     bmem_read    : burst request, held until bmem_ready
//     bmem_ready   : burst request accepted
//     bmem_rvalid  : burst beat valid
//     bmem_rdata   : burst beat data, beat 0 first
// ---------------------------------------------------------------------------
module imem_responder
    import rv32i_types::*;
#(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BMEM_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       imem_addr,
    input  logic [3:0]        imem_rmask,
    output logic [31:0]       imem_rdata,
    output logic              imem_resp,
    input  logic              inval,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    input  logic              bmem_ready,
    input  logic              bmem_rvalid,
    input  logic [BMEM_W-1:0] bmem_rdata
);

    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    imem_state_t        state_q;
    logic [31:2]        req_addr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               inval_pend_q;
    logic               imem_resp_q;
    logic [31:0]        imem_rdata_q;
    logic               bmem_read_q;
    logic [31:0]        bmem_addr_q;

    logic [31:0]         lb_word;
    logic [TAG_BITS-1:0] lb_tag;
    logic                lb_valid;
    logic [2:0]          word_sel;
    logic                lookup_hit;
    logic                beat_we;
    logic                fill_last;
    logic [31:0]         fill_word;

    logic unused_addr_bits;
    assign unused_addr_bits = ^imem_addr[1:0];

    // In IDLE the mux looks up the incoming address so a hit can be registered
    // straight into imem_rdata_q; otherwise it serves the latched request.
    assign word_sel   = (state_q == IDLE) ? imem_addr[4:2] : req_addr_q[4:2];
    assign lookup_hit = lb_valid && !inval && (lb_tag == imem_addr[31:OFFSET_BITS]);
    assign beat_we    = (state_q == MFILL) && bmem_rvalid;
    assign fill_last  = beat_we && (cnt_q == LAST_BEAT);

    // The last beat is written at the same edge the response is registered,
    // so when the requested word lives in that beat it is taken from the bus.
    always_comb begin
        fill_word = lb_word;
        if (req_addr_q[4:3] == cnt_q) begin
            fill_word = req_addr_q[2] ? bmem_rdata[63:32] : bmem_rdata[31:0];
        end
    end

    line_buffer #(
        .BEATS  (BEATS),
        .BMEM_W (BMEM_W)
    ) u_lb (
        .clk         (clk),
        .rst         (rst),
        .beat_we_i   (beat_we),
        .beat_idx_i  (cnt_q),
        .beat_data_i (bmem_rdata),
        .tag_we_i    (fill_last),
        // An invalidate seen anywhere in the miss leaves the new line invalid.
        .set_valid_i (!inval_pend_q),
        .tag_i       (req_addr_q[31:OFFSET_BITS]),
        .inval_i     (inval),
        .word_idx_i  (word_sel),
        .word_o      (lb_word),
        .tag_o       (lb_tag),
        .valid_o     (lb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            cnt_q        <= '0;
            inval_pend_q <= 1'b0;
            imem_resp_q  <= 1'b0;
            imem_rdata_q <= '0;
            bmem_read_q  <= 1'b0;
            bmem_addr_q  <= '0;
        end else begin
            imem_resp_q  <= 1'b0;
            imem_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|imem_rmask) begin
                        req_addr_q   <= imem_addr[31:2];
                        inval_pend_q <= 1'b0;
                        if (lookup_hit) begin
                            state_q      <= HIT;
                            imem_resp_q  <= 1'b1;
                            imem_rdata_q <= lb_word;
                        end else begin
                            state_q     <= MREQ;
                            bmem_read_q <= 1'b1;
                            bmem_addr_q <= {imem_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        end
                    end
                end
                MREQ: begin
                    if (inval) begin
                        inval_pend_q <= 1'b1;
                    end
                    if (bmem_ready) begin
                        bmem_read_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= MFILL;
                    end
                end
                MFILL: begin
                    if (inval) begin
                        inval_pend_q <= 1'b1;
                    end
                    if (bmem_rvalid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_q      <= RESP;
                            imem_resp_q  <= 1'b1;
                            imem_rdata_q <= fill_word;
                        end
                    end
                end
                HIT, RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_resp  = imem_resp_q;
    assign imem_rdata = imem_rdata_q;
    assign bmem_read  = bmem_read_q;
    assign bmem_addr  = bmem_addr_q;

endmodule
